noise_gate: RTL

- Downstream consumer of the moving-average noise filter; takes each filtered sample on its `done`/`sum` strobe.
- Mutes the signal when its level falls below a threshold: peak envelope follower, hysteresis thresholds, hold timer, linear gain ramps.
- Feeds the effects chain (distortion/delay) with one `done` strobe per input sample.

---
 rtl/noise_gate_pkg.sv | 37 +++
 rtl/noise_gate_if.sv | 12 +
 rtl/noise_gate_envelope_follower.sv | 32 +++
 rtl/noise_gate.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/noise_gate_pkg.sv
// Shared types and helpers for the noise gate: FSM state encoding, gain width,
// saturating magnitude and unsigned max used by the envelope path.
package noise_gate_pkg;

  localparam int DATA_W        = 24;
  localparam int GAIN_BITS_DEF = 8;
  localparam int GAIN_W        = GAIN_BITS_DEF + 1;
  localparam int FN_W          = 32;

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } gate_state_e;

  // |x| for a w-bit sample sign-extended to FN_W; the most negative value saturates.
  function automatic logic [FN_W-1:0] sat_abs(input logic signed [FN_W-1:0] x,
                                               input int unsigned            w);
    logic signed [FN_W-1:0] most_neg_v;
    most_neg_v = -(32'sd1 <<< (w - 32'd1));
    if (x == most_neg_v) begin
      return FN_W'(-(most_neg_v + 32'sd1));
    end else if (x < 32'sd0) begin
      return FN_W'(-x);
    end else begin
      return FN_W'(x);
    end
  endfunction

  function automatic logic [FN_W-1:0] umax(input logic [FN_W-1:0] a,
                                            input logic [FN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/noise_gate_if.sv
// Sample stream between the noise filter, the gate and the effects chain.
interface noise_gate_if import noise_gate_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W
) ();
  logic                         write;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         done;
  logic signed [DATA_WIDTH-1:0] data_out;

  modport master (output write, output data_in, input done, input data_out);
  modport slave  (input write, input data_in, output done, output data_out);
endinterface

// File: rtl/noise_gate_envelope_follower.sv
// Peak envelope with exponential decay; env_new is the level the gate FSM
// judges the current sample against, and it is committed only on write.
module envelope_follower import noise_gate_pkg::*; #(
  parameter int DATA_WIDTH  = DATA_W,
  parameter int DECAY_SHIFT = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         write,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic        [DATA_WIDTH-2:0] env_new
);
  logic [DATA_WIDTH-2:0] env_r;
  logic [DATA_WIDTH-2:0] abs_s;
  logic [DATA_WIDTH-2:0] decay_s;

  // Magnitude of the incoming sample versus the decayed previous peak.
  always_comb begin
    abs_s   = (DATA_WIDTH-1)'(sat_abs(FN_W'(data_in), DATA_WIDTH));
    decay_s = env_r - (env_r >> DECAY_SHIFT);
    env_new = (DATA_WIDTH-1)'(umax(FN_W'(abs_s), FN_W'(decay_s)));
  end

  // Envelope register, advanced once per accepted sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      env_r <= {(DATA_WIDTH-1){1'b0}};
    end else if (write) begin
      env_r <= env_new;
    end
  end
endmodule

// File: rtl/noise_gate.sv
// Noise gate: envelope-driven 5-state FSM sets a per-sample gain that scales the
// sample; write at edge T yields done in the cycle after edge T+2.
module noise_gate import noise_gate_pkg::*; #(
  parameter int DATA_WIDTH   = DATA_W,
  parameter int DECAY_SHIFT  = 8,
  parameter int GAIN_BITS    = GAIN_BITS_DEF,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 1,
  parameter int HOLD_SAMPLES = 480
) (
  input  logic                  clock,
  input  logic                  reset_n,
  noise_gate_if.slave           bus,
  input  logic                  enable,
  input  logic [DATA_WIDTH-2:0] open_thresh,
  input  logic [DATA_WIDTH-2:0] close_thresh,
  output logic                  gate_open
);
  localparam int GW       = GAIN_BITS + 1;
  localparam int PW       = DATA_WIDTH + GW;
  localparam int HOLD_EFF = (HOLD_SAMPLES < 1) ? 1 : HOLD_SAMPLES;
  localparam int HOLD_W   = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
  localparam logic [GW-1:0]     GAIN_MAX   = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GW-1:0]     GAIN_FIRST = (ATTACK_STEP >= (32'd1 << GAIN_BITS)) ?
                                             GAIN_MAX : GW'(ATTACK_STEP);
  localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLD_EFF - 1);

  gate_state_e                  state_r, state_nx_s;
  logic [GW-1:0]                gain_r, gain_nx_s, gain_up_s, gain_dn_s;
  logic [GW:0]                  gain_sum_s;
  logic [HOLD_W-1:0]            hold_r, hold_nx_s;
  logic [DATA_WIDTH-2:0]        env_new_s;
  logic signed [DATA_WIDTH-1:0] data1_r, out2_r, data_out_r;
  logic signed [PW-1:0]         prod_s;
  logic                         en1_r, v1_r, v2_r, open2_r, done_r, gate_open_r;

  envelope_follower #(
    .DATA_WIDTH (DATA_WIDTH),
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_env (
    .clock  (clock),
    .reset_n(reset_n),
    .write  (bus.write),
    .data_in(bus.data_in),
    .env_new(env_new_s)
  );

  // Gate FSM: one transition per sample, the new gain applies to that same sample.
  always_comb begin
    state_nx_s = state_r;
    gain_nx_s  = gain_r;
    hold_nx_s  = hold_r;
    gain_sum_s = {1'b0, gain_r} + (GW+1)'(ATTACK_STEP);
    if (gain_sum_s >= {1'b0, GAIN_MAX}) begin
      gain_up_s = GAIN_MAX;
    end else begin
      gain_up_s = gain_sum_s[GW-1:0];
    end
    if (gain_r >= GW'(RELEASE_STEP)) begin
      gain_dn_s = gain_r - GW'(RELEASE_STEP);
    end else begin
      gain_dn_s = {GW{1'b0}};
    end
    case (state_r)
      ST_CLOSED: begin
        if (env_new_s >= open_thresh) begin
          state_nx_s = ST_ATTACK;
          gain_nx_s  = GAIN_FIRST;
        end else begin
          gain_nx_s  = {GW{1'b0}};
        end
      end
      ST_ATTACK: begin
        gain_nx_s = gain_up_s;
        if (env_new_s < close_thresh) begin
          state_nx_s = ST_RELEASE;
        end else if (gain_up_s == GAIN_MAX) begin
          state_nx_s = ST_OPEN;
        end else begin
          state_nx_s = ST_ATTACK;
        end
      end
      ST_OPEN: begin
        gain_nx_s = GAIN_MAX;
        if (env_new_s < close_thresh) begin
          state_nx_s = ST_HOLD;
          hold_nx_s  = HOLD_INIT;
        end else begin
          state_nx_s = ST_OPEN;
        end
      end
      ST_HOLD: begin
        gain_nx_s = GAIN_MAX;
        if (env_new_s >= open_thresh) begin
          state_nx_s = ST_OPEN;
        end else if (hold_r == {HOLD_W{1'b0}}) begin
          state_nx_s = ST_RELEASE;
        end else begin
          hold_nx_s  = hold_r - HOLD_W'(1'b1);
        end
      end
      ST_RELEASE: begin
        gain_nx_s = gain_dn_s;
        if (env_new_s >= open_thresh) begin
          state_nx_s = ST_ATTACK;
        end else if (gain_dn_s == {GW{1'b0}}) begin
          state_nx_s = ST_CLOSED;
        end else begin
          state_nx_s = ST_RELEASE;
        end
      end
      default: begin
        state_nx_s = ST_CLOSED;
        gain_nx_s  = {GW{1'b0}};
        hold_nx_s  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // Stage 1: FSM state, gain and the sample itself, captured only on write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_CLOSED;
      gain_r  <= {GW{1'b0}};
      hold_r  <= {HOLD_W{1'b0}};
      data1_r <= {DATA_WIDTH{1'b0}};
      en1_r   <= 1'b0;
    end else if (bus.write) begin
      state_r <= state_nx_s;
      gain_r  <= gain_nx_s;
      hold_r  <= hold_nx_s;
      data1_r <= bus.data_in;
      en1_r   <= enable;
    end
  end

  // Signed sample times unsigned gain; the zero-extended gain keeps it positive.
  always_comb begin
    prod_s = PW'(data1_r) * PW'($signed({1'b0, gain_r}));
  end

  // Valid pipeline: a reset drops anything in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      v1_r   <= bus.write;
      v2_r   <= v1_r;
      done_r <= v2_r;
    end
  end

  // Stage 2: scaled (floor) or bypassed sample plus the matching gate flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out2_r  <= {DATA_WIDTH{1'b0}};
      open2_r <= 1'b0;
    end else if (v1_r) begin
      out2_r  <= en1_r ? DATA_WIDTH'(prod_s >>> GAIN_BITS) : data1_r;
      open2_r <= (state_r != ST_CLOSED);
    end
  end

  // Output register: data_out and gate_open move together with done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r  <= {DATA_WIDTH{1'b0}};
      gate_open_r <= 1'b0;
    end else if (v2_r) begin
      data_out_r  <= out2_r;
      gate_open_r <= open2_r;
    end
  end

  assign bus.done     = done_r;
  assign bus.data_out = data_out_r;
  assign gate_open    = gate_open_r;
endmodule
